// File: rtl/morse_rx_decoder.sv
// Morse receiver: times marks/spaces on a serial line and decodes letters A-H.
// Optional MORSE_RX_RAW_EN adds raw_pattern/raw_length debug snapshot ports.
module morse_rx_decoder #(
   parameter int UNIT_CYCLES        = 25_000_000,
   parameter int DASH_MIN_UNITS     = 2,
   parameter int GAP_UNITS          = 3,
   parameter int MARK_TIMEOUT_UNITS = 5
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic       line_in,
`ifdef MORSE_RX_RAW_EN
   output logic [3:0] raw_pattern,
   output logic [2:0] raw_length,
`endif
   output logic [2:0] letter_out,
   output logic       letter_valid,
   output logic       letter_error,
   output logic       busy
);

   localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
   localparam logic [CW-1:0] CYC_LAST = CW'(UNIT_CYCLES - 1);
   localparam logic [2:0] DASH_U = 3'(DASH_MIN_UNITS);
   localparam logic [2:0] GAP_U  = 3'(GAP_UNITS);
   localparam logic [2:0] TMO_U  = 3'(MARK_TIMEOUT_UNITS);

   typedef enum logic [2:0] {
      IDLE,
      MARK,
      SPACE,
      EMIT,
      WAIT_LOW
   } state_t;

   state_t state, state_n;

   logic sync1, sync2, line_prev;
   logic rise, fall;

   logic [CW-1:0] cyc_cnt;
   logic [2:0]    unit_cnt;
   logic [2:0]    unit_eff;
   logic          wrap;
   logic          clr_cnt;

   logic [3:0] sym_reg, sym_n;
   logic [2:0] sym_cnt, cnt_n;
   logic [2:0] code_n;
   logic       valid_n, err_n;
   logic [3:0] hit_code;

   // {hit, code}; hit = 0 for any pattern outside the A-H table
   function automatic logic [3:0] lookup(input logic [2:0] len,
                                         input logic [3:0] pat);
      logic [3:0] r;
      case ({len, pat})
         7'b010_0100: r = 4'b1_000;
         7'b100_1000: r = 4'b1_001;
         7'b100_1010: r = 4'b1_010;
         7'b011_1000: r = 4'b1_011;
         7'b001_0000: r = 4'b1_100;
         7'b100_0010: r = 4'b1_101;
         7'b011_1100: r = 4'b1_110;
         7'b100_0000: r = 4'b1_111;
         default:     r = 4'b0_000;
      endcase
      return r;
   endfunction

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         line_prev <= 1'b0;
      end else begin
         sync1     <= line_in;
         sync2     <= sync1;
         line_prev <= sync2;
      end
   end

   assign rise = sync2 & ~line_prev;
   assign fall = ~sync2 & line_prev;

   // Count the unit completing this cycle so an N-unit mark reads as N on its edge
   assign wrap     = (cyc_cnt == CYC_LAST);
   assign unit_eff = (wrap && unit_cnt != 3'd7) ? unit_cnt + 3'd1 : unit_cnt;
   assign clr_cnt  = rise | fall | (state_n != state) | ~enable;

   always_ff @(posedge clock) begin
      if (reset || clr_cnt) begin
         cyc_cnt  <= '0;
         unit_cnt <= 3'd0;
      end else if (wrap) begin
         cyc_cnt <= '0;
         if (unit_cnt != 3'd7)
            unit_cnt <= unit_cnt + 3'd1;
      end else begin
         cyc_cnt <= cyc_cnt + 1'b1;
      end
   end

   assign hit_code = lookup(sym_cnt, sym_reg);

   always_comb begin
      state_n = state;
      sym_n   = sym_reg;
      cnt_n   = sym_cnt;
      code_n  = letter_out;
      valid_n = 1'b0;
      err_n   = 1'b0;
      if (!enable) begin
         state_n = IDLE;
         sym_n   = 4'd0;
         cnt_n   = 3'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (rise)
                  state_n = MARK;
            end
            MARK: begin
               if (fall) begin
                  if (unit_eff == 3'd0) begin
                     state_n = (sym_cnt != 3'd0) ? SPACE : IDLE;
                  end else if (sym_cnt == 3'd4) begin
                     err_n   = 1'b1;
                     sym_n   = 4'd0;
                     cnt_n   = 3'd0;
                     state_n = IDLE;
                  end else begin
                     if (unit_eff >= DASH_U)
                        sym_n = sym_reg | (4'b1000 >> sym_cnt);
                     cnt_n   = sym_cnt + 3'd1;
                     state_n = SPACE;
                  end
               end else if (unit_eff >= TMO_U) begin
                  err_n   = 1'b1;
                  sym_n   = 4'd0;
                  cnt_n   = 3'd0;
                  state_n = WAIT_LOW;
               end
            end
            SPACE: begin
               // gap threshold has priority over a coincident rising edge
               if (unit_eff >= GAP_U)
                  state_n = EMIT;
               else if (rise)
                  state_n = MARK;
            end
            EMIT: begin
               if (hit_code[3]) begin
                  valid_n = 1'b1;
                  code_n  = hit_code[2:0];
               end else begin
                  err_n = 1'b1;
               end
               sym_n   = 4'd0;
               cnt_n   = 3'd0;
               state_n = IDLE;
            end
            WAIT_LOW: begin
               if (!sync2)
                  state_n = IDLE;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         sym_reg      <= 4'd0;
         sym_cnt      <= 3'd0;
         letter_out   <= 3'd0;
         letter_valid <= 1'b0;
         letter_error <= 1'b0;
      end else begin
         state        <= state_n;
         sym_reg      <= sym_n;
         sym_cnt      <= cnt_n;
         letter_out   <= code_n;
         letter_valid <= valid_n;
         letter_error <= err_n;
      end
   end

`ifdef MORSE_RX_RAW_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         raw_pattern <= 4'd0;
         raw_length  <= 3'd0;
      end else if (valid_n || err_n) begin
         raw_pattern <= sym_reg;
         raw_length  <= sym_cnt;
      end
   end
`endif

   assign busy = (state != IDLE);

endmodule
